// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared definitions for the staged reset sequencer:
//   - seq_state_t : sequencer FSM states
//   - sw_of()     : width of a stage index for a given number of stages
// -----------------------------------------------------------------------------
package reset_seq_pkg;

    typedef enum logic [2:0] {
        S_HOLD     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_GAP      = 3'd2,
        S_DONE     = 3'd3,
        S_FAULT    = 3'd4
    } seq_state_t;

    // A single stage still needs a 1-bit index so that ports never collapse
    // to zero width.
    function automatic int sw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_seq_timer.sv
// -----------------------------------------------------------------------------
// seq_timer
// Unsigned CNT_W-bit cycle counter shared by the hold, gap and timeout phases.
//   i_clk    : system clock
//   i_rst    : asynchronous active-high reset
//   i_clr    : synchronous clear (wins over enable)
//   i_en     : count enable
//   i_limit  : terminal count, >= 1
//   o_expire : high while enabled and the count equals i_limit-1
// The counter saturates at i_limit-1 and never wraps.
// -----------------------------------------------------------------------------
module seq_timer #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_term;

    assign w_term   = i_limit - 1'b1;
    assign o_expire = i_en && (r_cnt == w_term);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != w_term)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Releases per-subsystem resets one stage at a time, in index order. Each stage
// waits for the previous stage's ready plus an inter-stage gap, and a stage
// that never becomes ready (or a ready that drops once all stages are up)
// forces every reset back on and reports the faulting stage.
//
// Ports:
//   clk          : system clock
//   rst_in       : asynchronous active-high reset
//   soft_rst     : synchronous restart of the whole sequence (highest priority)
//   stage_ready  : per-stage ready/lock, sampled on clk
//   rst_out      : per-stage reset, active high, registered
//   all_ready    : every stage released and ready
//   fault        : timeout or ready loss detected
//   fault_stage  : index of the faulting stage
//
// Build option: define RESET_SEQ_TIMEOUT_EN to enable the ready timeout.
// Without it the sequencer waits for ready indefinitely and only a ready loss
// after completion can raise fault.
// -----------------------------------------------------------------------------
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int          NUM_STAGES = 4,
    parameter int unsigned DELAY      = 32'hfffff,
    parameter int unsigned GAP        = 32'h3ff,
    parameter int unsigned TIMEOUT    = 32'hffffff,
    parameter int          CNT_W      = 32
) (
    input  logic                             clk,
    input  logic                             rst_in,
    input  logic                             soft_rst,
    input  logic [NUM_STAGES-1:0]            stage_ready,
    output logic [NUM_STAGES-1:0]            rst_out,
    output logic                             all_ready,
    output logic                             fault,
    output logic [sw_of(NUM_STAGES)-1:0]     fault_stage
);

    localparam int               SW        = sw_of(NUM_STAGES);
    localparam logic [CNT_W-1:0] L_DELAY   = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] L_GAP     = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [SW-1:0]    L_LAST    = SW'(NUM_STAGES - 1);

    function automatic logic [SW-1:0] lowest_set(input logic [NUM_STAGES-1:0] v);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (v[i]) idx = SW'(i);
        end
        return idx;
    endfunction

    seq_state_t              r_state, w_nxt_state;
    logic [SW-1:0]           r_k, w_nxt_k, w_k_inc;
    logic [NUM_STAGES-1:0]   r_rst_out, w_nxt_rst_out;
    logic                    r_all_ready, w_nxt_all_ready;
    logic                    r_fault, w_nxt_fault;
    logic [SW-1:0]           r_fault_stage, w_nxt_fault_stage;
    logic [NUM_STAGES-1:0]   r_ready_p0;
    logic                    w_rdy_k;
    logic [NUM_STAGES-1:0]   w_drop;
    logic                    w_tmr_clr, w_tmr_en, w_expire;
    logic [CNT_W-1:0]        w_limit;

    assign w_k_inc = r_k + 1'b1;
    // Ready loss is judged on the registered copy, so a drop sampled on one
    // edge takes effect on the following edge.
    assign w_drop  = ~r_ready_p0;

    always_comb begin
        w_rdy_k = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (r_k == SW'(i)) w_rdy_k = stage_ready[i];
        end
    end

    // Timer phase selection
    always_comb begin
        w_limit  = L_DELAY;
        w_tmr_en = 1'b0;
        case (r_state)
            S_HOLD:     begin w_limit = L_DELAY;   w_tmr_en = 1'b1; end
            S_GAP:      begin w_limit = L_GAP;     w_tmr_en = 1'b1; end
            S_WAIT_RDY: begin w_limit = L_TIMEOUT; w_tmr_en = 1'b1; end
            default:    begin w_limit = L_DELAY;   w_tmr_en = 1'b0; end
        endcase
    end

    // Every state entry restarts the count; soft_rst also restarts it when
    // the sequencer is already in HOLD.
    assign w_tmr_clr = soft_rst || (w_nxt_state != r_state);

    seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk    (clk),
        .i_rst    (rst_in),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .i_limit  (w_limit),
        .o_expire (w_expire)
    );

    // Next-state and next-output logic
    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_k           = r_k;
        w_nxt_rst_out     = r_rst_out;
        w_nxt_all_ready   = r_all_ready;
        w_nxt_fault       = r_fault;
        w_nxt_fault_stage = r_fault_stage;

        if (soft_rst) begin
            w_nxt_state       = S_HOLD;
            w_nxt_k           = '0;
            w_nxt_rst_out     = '1;
            w_nxt_all_ready   = 1'b0;
            w_nxt_fault       = 1'b0;
            w_nxt_fault_stage = '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (w_expire) begin
                        w_nxt_rst_out[0] = 1'b0;
                        w_nxt_state      = S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    // Ready on the terminal timeout edge still counts as ready.
                    if (w_rdy_k) begin
                        if (r_k == L_LAST) begin
                            w_nxt_state     = S_DONE;
                            w_nxt_all_ready = 1'b1;
                        end else begin
                            w_nxt_state = S_GAP;
                        end
                    end
`ifdef RESET_SEQ_TIMEOUT_EN
                    else if (w_expire) begin
                        w_nxt_state       = S_FAULT;
                        w_nxt_rst_out     = '1;
                        w_nxt_fault       = 1'b1;
                        w_nxt_fault_stage = r_k;
                    end
`endif
                end
                S_GAP: begin
                    if (w_expire) begin
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            if (w_k_inc == SW'(i)) w_nxt_rst_out[i] = 1'b0;
                        end
                        w_nxt_k     = w_k_inc;
                        w_nxt_state = S_WAIT_RDY;
                    end
                end
                S_DONE: begin
                    if (|w_drop) begin
                        w_nxt_state       = S_FAULT;
                        w_nxt_rst_out     = '1;
                        w_nxt_all_ready   = 1'b0;
                        w_nxt_fault       = 1'b1;
                        w_nxt_fault_stage = lowest_set(w_drop);
                    end
                end
                S_FAULT: begin
                    w_nxt_state = S_FAULT;
                end
                default: begin
                    w_nxt_state   = S_FAULT;
                    w_nxt_rst_out = '1;
                    w_nxt_fault   = 1'b1;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_state       <= S_HOLD;
            r_k           <= '0;
            r_rst_out     <= '1;
            r_all_ready   <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_stage <= '0;
        end else begin
            r_state       <= w_nxt_state;
            r_k           <= w_nxt_k;
            r_rst_out     <= w_nxt_rst_out;
            r_all_ready   <= w_nxt_all_ready;
            r_fault       <= w_nxt_fault;
            r_fault_stage <= w_nxt_fault_stage;
        end
    end

    // Input sample for ready-loss detection
    always_ff @(posedge clk) begin
        r_ready_p0 <= stage_ready;
    end

    assign rst_out     = r_rst_out;
    assign all_ready   = r_all_ready;
    assign fault       = r_fault;
    assign fault_stage = r_fault_stage;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Directed bench for reset_sequencer with NUM_STAGES=3, DELAY=4, GAP=2,
// TIMEOUT=8. Expected outputs are queued before each clock edge and popped
// and compared one time unit after that edge.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    logic       clk;
    logic       rst_in;
    logic       soft_rst;
    logic [2:0] stage_ready;
    logic [2:0] rst_out;
    logic       all_ready;
    logic       fault;
    logic [1:0] fault_stage;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } sb_item_t;

    sb_item_t sb[$];

    reset_sequencer #(
        .NUM_STAGES (3),
        .DELAY      (4),
        .GAP        (2),
        .TIMEOUT    (8),
        .CNT_W      (32)
    ) dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .soft_rst    (soft_rst),
        .stage_ready (stage_ready),
        .rst_out     (rst_out),
        .all_ready   (all_ready),
        .fault       (fault),
        .fault_stage (fault_stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rst_out expected n edges after the sequence (re)starts, all stages ready.
    function automatic logic [2:0] nom_rst(input int n);
        if (n < 4)  return 3'b111;
        if (n < 7)  return 3'b110;
        if (n < 10) return 3'b100;
        return 3'b000;
    endfunction

    task automatic push_exp(input string tag, input logic [2:0] r, input logic a,
                            input logic f, input logic [1:0] fs);
        sb_item_t it;
        it.tag = tag;
        it.exp = {r, a, f, fs};
        sb.push_back(it);
    endtask

    task automatic check_head();
        sb_item_t   it;
        logic [6:0] obs;
        it  = sb.pop_front();
        obs = {rst_out, all_ready, fault, fault_stage};
        vectors++;
        assert (obs === it.exp) else begin
            miscompares++;
            $error("FAIL %s: observed {rst_out,all_ready,fault,fault_stage}=%b required %b",
                   it.tag, obs, it.exp);
        end
    endtask

    task automatic expect_edge(input string tag, input logic [2:0] r, input logic a,
                               input logic f, input logic [1:0] fs);
        push_exp(tag, r, a, f, fs);
        @(posedge clk);
        #1;
        check_head();
    endtask

    task automatic expect_now(input string tag, input logic [2:0] r, input logic a,
                              input logic f, input logic [1:0] fs);
        push_exp(tag, r, a, f, fs);
        check_head();
    endtask

    task automatic nominal(input string tag, input int n);
        for (int i = 1; i <= n; i++) begin
            expect_edge($sformatf("%s_e%0d", tag, i), nom_rst(i), (i >= 11), 1'b0, 2'd0);
        end
    endtask

    task automatic restart(input string tag);
        soft_rst = 1'b1;
        expect_edge(tag, 3'b111, 1'b0, 1'b0, 2'd0);
        soft_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in      = 1'b1;
        soft_rst    = 1'b0;
        stage_ready = 3'b111;
        #2;
        expect_now("reset_async", 3'b111, 1'b0, 1'b0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        expect_now("reset_hold", 3'b111, 1'b0, 1'b0, 2'd0);
        rst_in = 1'b0;

        // Nominal sequence with every ready tied high
        nominal("nom", 11);
        repeat (2) expect_edge("done_hold", 3'b000, 1'b1, 1'b0, 2'd0);

        // Ready loss on stages 0 and 2 in DONE
        stage_ready = 3'b010;
        expect_edge("loss_sample", 3'b000, 1'b1, 1'b0, 2'd0);
        expect_edge("loss_fault", 3'b111, 1'b0, 1'b1, 2'd0);
        stage_ready = 3'b111;
        expect_edge("fault_hold", 3'b111, 1'b0, 1'b1, 2'd0);

        // soft_rst in FAULT, then the nominal timing again
        restart("soft_in_fault");
        nominal("after_soft_fault", 11);

        // soft_rst in GAP
        restart("soft_kick");
        nominal("to_gap", 5);
        restart("soft_in_gap");
        nominal("after_soft_gap", 11);

        // Asynchronous rst_in mid-GAP
        restart("soft_kick2");
        nominal("to_gap2", 8);
        #3;
        rst_in = 1'b1;
        #1;
        expect_now("async_rst_gap", 3'b111, 1'b0, 1'b0, 2'd0);
        #2;
        rst_in = 1'b0;
        nominal("after_rst", 11);

        // Stage 1 never ready; stage 2 ready is ignored while sequencing
        stage_ready = 3'b101;
        restart("soft_kick3");
        for (int i = 1; i <= 7; i++) begin
            expect_edge($sformatf("stall_e%0d", i), nom_rst(i), 1'b0, 1'b0, 2'd0);
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        for (int i = 8; i <= 14; i++) begin
            expect_edge($sformatf("stall_e%0d", i), 3'b100, 1'b0, 1'b0, 2'd0);
        end
        expect_edge("timeout_fault", 3'b111, 1'b0, 1'b1, 2'd1);
        stage_ready = 3'b111;
        expect_edge("timeout_hold", 3'b111, 1'b0, 1'b1, 2'd1);

        // Ready arriving on the terminal timeout edge wins
        stage_ready = 3'b101;
        restart("soft_kick4");
        for (int i = 1; i <= 14; i++) begin
            expect_edge($sformatf("late_e%0d", i), (i < 7) ? nom_rst(i) : 3'b100,
                        1'b0, 1'b0, 2'd0);
        end
        stage_ready = 3'b111;
        expect_edge("late_ready_wins", 3'b100, 1'b0, 1'b0, 2'd0);
        expect_edge("late_gap", 3'b100, 1'b0, 1'b0, 2'd0);
        expect_edge("late_release2", 3'b000, 1'b0, 1'b0, 2'd0);
        expect_edge("late_done", 3'b000, 1'b1, 1'b0, 2'd0);
`else
        for (int i = 0; i < 1000; i++) begin
            expect_edge($sformatf("wait_c%0d", i), 3'b100, 1'b0, 1'b0, 2'd0);
        end
        stage_ready = 3'b111;
        expect_edge("wait_ready", 3'b100, 1'b0, 1'b0, 2'd0);
        expect_edge("wait_gap", 3'b100, 1'b0, 1'b0, 2'd0);
        expect_edge("wait_release2", 3'b000, 1'b0, 1'b0, 2'd0);
        expect_edge("wait_done", 3'b000, 1'b1, 1'b0, 2'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
